// File: rtl/haz_resolver_mc_pkg.sv
// Shared types for the multi-lane hazard resolver: FSM state encoding and helpers.
package haz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CTRL  = 3'd1,
    ST_DATA  = 3'd2,
    ST_STR   = 3'd3,
    ST_FLUSH = 3'd4
  } haz_state_t;

  // Encodings 5-7 are unreachable in normal operation; an upset lands here.
  localparam haz_state_t ST_RECOVER = ST_IDLE;

  function automatic logic is_stall_state(input haz_state_t s);
    return (s == ST_CTRL) || (s == ST_DATA) || (s == ST_STR);
  endfunction

endpackage

// File: rtl/haz_resolver_mc_if.sv
// Bundle between hazard detectors / pipeline enables and the resolver.
interface haz_resolver_mc_if #(
  parameter int LANES = 2,
  parameter int CNT_W = 8
);
  logic             ena;
  logic             ctrl;
  logic             branch;
  logic             crct;
  logic [LANES-1:0] data;
  logic [LANES-1:0] fwrd;
  logic             str;
  logic             stall;
  logic             flush;
  logic             bubble;
  logic [LANES-1:0] fwd_en;
  logic [2:0]       state;
  logic             timeout_err;
  logic [CNT_W-1:0] mispred_cnt;
  logic [CNT_W-1:0] stall_cyc_cnt;

  modport master (
    output ena, ctrl, branch, crct, data, fwrd, str,
    input  stall, flush, bubble, fwd_en, state, timeout_err, mispred_cnt, stall_cyc_cnt
  );

  modport slave (
    input  ena, ctrl, branch, crct, data, fwrd, str,
    output stall, flush, bubble, fwd_en, state, timeout_err, mispred_cnt, stall_cyc_cnt
  );
endinterface

// File: rtl/haz_resolver_mc_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_ena,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_ena) begin
      if (i_clr)
        r_cnt <= '0;
      else if (i_inc && (r_cnt != {W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/haz_resolver_mc.sv
// Multi-lane pipeline hazard resolver: prioritised stall/flush FSM with
// multi-cycle flush, stall watchdog and saturating event counters.
import haz_pkg::*;

module haz_resolver_mc #(
  parameter int LANES        = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_STALL    = 8,
  parameter int CNT_W        = 8
) (
  input logic               clk,
  input logic               rst,
  haz_resolver_mc_if.slave  bus
);

  localparam int RUN_W = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
  localparam int FC_W  = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  haz_state_t       r_state;
  haz_state_t       w_next;
  logic [FC_W-1:0]  r_fcnt;
  logic             r_stall;
  logic             r_flush;
  logic             r_bubble;
  logic [LANES-1:0] r_fwd;
  logic             r_terr;

  logic             w_dhaz;
  logic             w_mis;
  logic             w_fire;
  logic             w_eval;
  logic             w_mis_take;
  logic             w_load;
  logic [RUN_W-1:0] w_run;

  assign w_dhaz = |(bus.data & ~bus.fwrd);
  assign w_mis  = bus.branch & ~bus.crct;

  // Fires in the last of MAX_STALL consecutive stall cycles, so FLUSH follows it.
  assign w_fire = (MAX_STALL != 0) && r_stall && (w_run == RUN_W'(MAX_STALL - 1));

  always_comb begin
    w_next     = r_state;
    w_eval     = 1'b0;
    w_mis_take = 1'b0;
    case (r_state)
      ST_IDLE, ST_CTRL, ST_DATA, ST_STR: w_eval = 1'b1;
      ST_FLUSH:                          w_eval = (r_fcnt == FC_W'(1));
      default:                           w_next = ST_RECOVER;
    endcase
    if (w_eval) begin
      if (w_fire) begin
        w_next = ST_FLUSH;
      end else if (w_mis) begin
        w_next     = ST_FLUSH;
        w_mis_take = 1'b1;
      end else if (bus.ctrl && !bus.branch) begin
        w_next = ST_CTRL;
      end else if (w_dhaz) begin
        w_next = ST_DATA;
      end else if (bus.str) begin
        w_next = ST_STR;
      end else begin
        w_next = ST_IDLE;
      end
    end
  end

  assign w_load = w_eval && (w_next == ST_FLUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_fcnt   <= '0;
      r_stall  <= 1'b0;
      r_flush  <= 1'b0;
      r_bubble <= 1'b0;
      r_fwd    <= '0;
      r_terr   <= 1'b0;
    end else if (bus.ena) begin
      r_state  <= w_next;
      r_stall  <= is_stall_state(w_next);
      r_bubble <= (w_next == ST_DATA) || (w_next == ST_STR);
      r_flush  <= (w_next == ST_FLUSH);
      if (w_load)
        r_fcnt <= FC_W'(FLUSH_CYCLES);
      else if ((r_state == ST_FLUSH) && (r_fcnt != '0))
        r_fcnt <= r_fcnt - 1'b1;
      if ((w_next == ST_FLUSH) || (r_state == ST_FLUSH))
        r_fwd <= '0;
      else
        r_fwd <= bus.data & bus.fwrd;
      if (w_fire)
        r_terr <= 1'b1;
    end
  end

  sat_counter #(.W(RUN_W)) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_ena (bus.ena),
    .i_inc (r_stall),
    .i_clr (!r_stall || w_load),
    .o_cnt (w_run)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_ena (bus.ena),
    .i_inc (w_mis_take),
    .i_clr (1'b0),
    .o_cnt (bus.mispred_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_ena (bus.ena),
    .i_inc (r_stall),
    .i_clr (1'b0),
    .o_cnt (bus.stall_cyc_cnt)
  );

  assign bus.state       = r_state;
  assign bus.stall       = r_stall;
  assign bus.flush       = r_flush;
  assign bus.bubble      = r_bubble;
  assign bus.fwd_en      = r_fwd;
  assign bus.timeout_err = r_terr;

endmodule

// File: tb/tb_haz_resolver_mc.sv
// Directed bench for haz_resolver_mc; a second instance with CNT_W=2 covers saturation.
module tb_haz_resolver_mc;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       ctrl;
  logic       branch;
  logic       crct;
  logic [1:0] data;
  logic [1:0] fwrd;
  logic       str;

  int n_chk  = 0;
  int n_pass = 0;

  haz_resolver_mc_if #(.LANES(2), .CNT_W(8)) bus  ();
  haz_resolver_mc_if #(.LANES(2), .CNT_W(2)) bus2 ();

  assign bus.ena     = ena;
  assign bus.ctrl    = ctrl;
  assign bus.branch  = branch;
  assign bus.crct    = crct;
  assign bus.data    = data;
  assign bus.fwrd    = fwrd;
  assign bus.str     = str;
  assign bus2.ena    = ena;
  assign bus2.ctrl   = ctrl;
  assign bus2.branch = branch;
  assign bus2.crct   = crct;
  assign bus2.data   = data;
  assign bus2.fwrd   = fwrd;
  assign bus2.str    = str;

  haz_resolver_mc #(.LANES(2), .FLUSH_CYCLES(2), .MAX_STALL(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  haz_resolver_mc #(.LANES(2), .FLUSH_CYCLES(2), .MAX_STALL(8), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    ctrl   = 1'b0;
    branch = 1'b0;
    crct   = 1'b0;
    data   = 2'b00;
    fwrd   = 2'b00;
    str    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    clr_in();
    step();
    step();
    rst = 1'b0;
    chk("rst_state",   32'(bus.state), 0);
    chk("rst_stall",   32'(bus.stall), 0);
    chk("rst_flush",   32'(bus.flush), 0);
    chk("rst_bubble",  32'(bus.bubble), 0);
    chk("rst_fwd",     32'(bus.fwd_en), 0);
    chk("rst_terr",    32'(bus.timeout_err), 0);
    chk("rst_mispred", 32'(bus.mispred_cnt), 0);
    chk("rst_stcnt",   32'(bus.stall_cyc_cnt), 0);

    // 1: control hazard held three cycles, then correct resolve
    ctrl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_state", 32'(bus.state), 1);
      chk("t1_stall", 32'(bus.stall), 1);
      chk("t1_flush", 32'(bus.flush), 0);
    end
    branch = 1'b1;
    crct   = 1'b1;
    step();
    chk("t1_idle",  32'(bus.state), 0);
    chk("t1_stall0", 32'(bus.stall), 0);
    chk("t1_flush0", 32'(bus.flush), 0);
    chk("t1_stcnt", 32'(bus.stall_cyc_cnt), 3);

    // 2: mispredict, flush for two cycles with forwarding suppressed
    ctrl   = 1'b1;
    branch = 1'b1;
    crct   = 1'b0;
    data   = 2'b01;
    fwrd   = 2'b01;
    step();
    chk("t2_state",   32'(bus.state), 4);
    chk("t2_flush1",  32'(bus.flush), 1);
    chk("t2_stall",   32'(bus.stall), 0);
    chk("t2_fwd1",    32'(bus.fwd_en), 0);
    chk("t2_mispred", 32'(bus.mispred_cnt), 1);
    ctrl   = 1'b0;
    branch = 1'b0;
    step();
    chk("t2_flush2", 32'(bus.flush), 1);
    chk("t2_fwd2",   32'(bus.fwd_en), 0);
    data = 2'b00;
    fwrd = 2'b00;
    step();
    chk("t2_idle",     32'(bus.state), 0);
    chk("t2_flush3",   32'(bus.flush), 0);
    chk("t2_mispred2", 32'(bus.mispred_cnt), 1);

    // 3: two-lane RAW, lane 1 unforwardable then forwardable
    data = 2'b11;
    fwrd = 2'b01;
    step();
    chk("t3a_state",  32'(bus.state), 2);
    chk("t3a_stall",  32'(bus.stall), 1);
    chk("t3a_bubble", 32'(bus.bubble), 1);
    chk("t3a_fwd",    32'(bus.fwd_en), 2'b01);
    fwrd = 2'b11;
    step();
    chk("t3b_state", 32'(bus.state), 0);
    chk("t3b_stall", 32'(bus.stall), 0);
    chk("t3b_fwd",   32'(bus.fwd_en), 2'b11);
    chk("t3b_stcnt", 32'(bus.stall_cyc_cnt), 4);

    // 4: data beats structural, mispredict preempts DATA
    data = 2'b01;
    fwrd = 2'b00;
    str  = 1'b1;
    step();
    chk("t4_data1", 32'(bus.state), 2);
    step();
    chk("t4_data2", 32'(bus.state), 2);
    branch = 1'b1;
    crct   = 1'b0;
    step();
    chk("t4_flush",   32'(bus.state), 4);
    chk("t4_stall0",  32'(bus.stall), 0);
    chk("t4_mispred", 32'(bus.mispred_cnt), 2);
    chk("t4_stcnt",   32'(bus.stall_cyc_cnt), 6);
    branch = 1'b0;
    data   = 2'b00;
    step();
    chk("t4_flush2", 32'(bus.state), 4);
    step();
    chk("t4_str", 32'(bus.state), 3);

    // 5: str held -> watchdog after eight stall cycles
    for (int i = 2; i <= 8; i++) begin
      step();
      chk("t5_str",   32'(bus.state), 3);
      chk("t5_stall", 32'(bus.stall), 1);
      chk("t5_terr0", 32'(bus.timeout_err), 0);
    end
    step();
    chk("t5_wd_flush", 32'(bus.state), 4);
    chk("t5_terr",     32'(bus.timeout_err), 1);
    chk("t5_mispred",  32'(bus.mispred_cnt), 2);
    step();
    chk("t5_wd_flush2", 32'(bus.flush), 1);
    step();
    chk("t5_restr", 32'(bus.state), 3);
    chk("t5_terr_sticky", 32'(bus.timeout_err), 1);
    chk("t5_stcnt", 32'(bus.stall_cyc_cnt), 14);
    str = 1'b0;
    step();
    chk("t5_idle",   32'(bus.state), 0);
    chk("t5_stcnt2", 32'(bus.stall_cyc_cnt), 15);
    chk("t5_terr2",  32'(bus.timeout_err), 1);
    chk("t5_d2_stcnt",   32'(bus2.stall_cyc_cnt), 3);
    chk("t5_d2_mispred", 32'(bus2.mispred_cnt), 2);

    // 6a: five more mispredicts; narrow counter saturates
    for (int i = 0; i < 5; i++) begin
      branch = 1'b1;
      crct   = 1'b0;
      step();
      branch = 1'b0;
      step();
      step();
    end
    chk("t6a_state",      32'(bus.state), 0);
    chk("t6a_mispred",    32'(bus.mispred_cnt), 7);
    chk("t6a_d2_mispred", 32'(bus2.mispred_cnt), 3);

    // 6b: ena=0 freezes DATA despite a pending mispredict
    data = 2'b01;
    fwrd = 2'b00;
    step();
    chk("t6b_data", 32'(bus.state), 2);
    ena    = 1'b0;
    data   = 2'b00;
    branch = 1'b1;
    crct   = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t6b_hold_state",  32'(bus.state), 2);
    chk("t6b_hold_stall",  32'(bus.stall), 1);
    chk("t6b_hold_bubble", 32'(bus.bubble), 1);
    chk("t6b_hold_stcnt",  32'(bus.stall_cyc_cnt), 15);
    chk("t6b_hold_mis",    32'(bus.mispred_cnt), 7);
    ena    = 1'b1;
    branch = 1'b0;
    step();
    chk("t6b_resume", 32'(bus.state), 0);
    chk("t6b_stcnt",  32'(bus.stall_cyc_cnt), 16);

    // 6c: async reset between edges mid-flush
    branch = 1'b1;
    crct   = 1'b0;
    step();
    chk("t6c_flush",   32'(bus.flush), 1);
    chk("t6c_mispred", 32'(bus.mispred_cnt), 8);
    branch = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6c_rst_state", 32'(bus.state), 0);
    chk("t6c_rst_flush", 32'(bus.flush), 0);
    chk("t6c_rst_mis",   32'(bus.mispred_cnt), 0);
    chk("t6c_rst_stcnt", 32'(bus.stall_cyc_cnt), 0);
    chk("t6c_rst_terr",  32'(bus.timeout_err), 0);
    #2;
    rst = 1'b0;
    step();
    chk("t6c_post_state", 32'(bus.state), 0);
    chk("t6c_post_flush", 32'(bus.flush), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
